// File: rtl/acc_seq.sv
// Sequential 32-bit accumulator that time-shares an external ripple-carry adder.
// Optional sticky wrap detection is enabled by defining ACC_SEQ_OVF_DETECT_EN.
module acc_seq #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_en,
    input  logic [31:0]      add_z,
    output logic [31:0]      sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitIn = 2'd1,
        StSettle = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       settle_q, settle_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= 32'h0;
            b_q      <= 32'h0;
            rem_q    <= '0;
            settle_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        rem_d     = rem_q;
        settle_d  = settle_q;
        in_ready  = 1'b0;
        add_en    = 1'b0;
        add_a     = 32'h0;
        add_b     = 32'h0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = 32'h0;
                    rem_d   = num_words;
                    state_d = (num_words == '0) ? StDone : StWaitIn;
                end
            end
            StWaitIn: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d      = in_data;
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                add_en = 1'b1;
                add_a  = acc_q;
                add_b  = b_q;
                // Adder output is only trusted once the operands have been held long enough.
                if (settle_q == 4'h0) begin
                    acc_d   = add_z;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? StDone : StWaitIn;
                end else begin
                    settle_d = settle_q - 4'h1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum  = acc_q;
    assign busy = (state_q != StIdle);

`ifdef ACC_SEQ_OVF_DETECT_EN
    logic ovf_q;

    // A result smaller than the accumulator operand means the unsigned add wrapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            ovf_q <= 1'b0;
        end else if (state_q == StSettle && settle_q == 4'h0 && add_z < add_a) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_acc_seq.sv
// Table-driven bench for acc_seq; the bench supplies the external adder as a plain 32-bit add.
module tb_acc_seq;

    localparam int unsigned S = 2;
`ifdef ACC_SEQ_OVF_DETECT_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, add_en, out_valid, out_ready, busy, ovf;
    logic [7:0]  num_words;
    logic [31:0] in_data, add_a, add_b, add_z, sum;

    int n_cmp = 0;
    int n_fail = 0;

    acc_seq #(.SETTLE_CYC(S), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_z     (add_z),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    assign add_z = add_a + add_b;

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] ops [4];
        int          stall_at;
        int          stall;
        int          hold;
        bit          pulse;
        logic [31:0] exp_sum;
        bit          wrap;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int n, logic [31:0] o0, logic [31:0] o1, logic [31:0] o2,
                                logic [31:0] o3, int stall_at, int stall, int hold, bit pulse,
                                logic [31:0] s, bit wrap, int cyc);
        vec_t v;
        v.n = n;
        v.ops[0] = o0;
        v.ops[1] = o1;
        v.ops[2] = o2;
        v.ops[3] = o3;
        v.stall_at = stall_at;
        v.stall = stall;
        v.hold = hold;
        v.pulse = pulse;
        v.exp_sum = s;
        v.wrap = wrap;
        v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        int en_cnt = 0;
        bit hs;
        start = 1'b1;
        num_words = 8'(v.n);
        tick();
        start = 1'b0;
        while (!out_valid && cyc < v.exp_cyc + 50) begin
            if (in_ready && idx == v.stall_at && stalled < v.stall) begin
                in_valid = 1'b0;
                stalled++;
                check("stall_add_en", {31'h0, add_en}, 32'h0);
            end else begin
                in_valid = (idx < v.n);
                in_data = (idx < v.n) ? v.ops[idx] : 32'h0;
            end
            if (add_en) begin
                en_cnt++;
                check("settle_in_ready", {31'h0, in_ready}, 32'h0);
                check("settle_add_b", add_b, v.ops[idx-1]);
            end else begin
                check("idle_add_ab", add_a | add_b, 32'h0);
            end
            hs = in_ready && in_valid;
            tick();
            cyc++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        $display("vec %0d: %0d busy cycles", id, cyc);
        check("done_reached", {31'h0, out_valid}, 32'h1);
        check("busy_cycles", cyc, v.exp_cyc);
        check("add_en_cycles", en_cnt, v.n * S);
        check("sum", sum, v.exp_sum);
        check("ovf", {31'h0, ovf}, {31'h0, v.wrap & OvfEn});
        check("busy_done", {31'h0, busy}, 32'h1);
        for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            start = v.pulse && (h == 2);
            tick();
            start = 1'b0;
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_sum", sum, v.exp_sum);
        end
        out_ready = 1'b1;
        start = v.pulse;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_valid", {31'h0, out_valid}, 32'h0);
        check("idle_sum", sum, v.exp_sum);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_words = 8'h0;
        in_data = 32'h0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_add_en", {31'h0, add_en}, 32'h0);
        check("rst_add_ab", add_a | add_b, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_sum", sum, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        rst = 1'b0;
        tick();

        vecs[0] = mk(3, 32'd5, 32'd7, 32'd9, 32'd0, -1, 0, 0, 1'b0, 32'd21, 1'b0, 9);
        vecs[1] = mk(0, 32'd0, 32'd0, 32'd0, 32'd0, -1, 0, 0, 1'b0, 32'd0, 1'b0, 0);
        vecs[2] = mk(2, 32'hFFFF_FFFF, 32'h2, 32'd0, 32'd0, -1, 0, 0, 1'b0, 32'h1, 1'b1, 6);
        vecs[3] = mk(2, 32'd3, 32'd4, 32'd0, 32'd0, 1, 10, 0, 1'b0, 32'd7, 1'b0, 16);
        vecs[4] = mk(4, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, -1, 0, 5, 1'b1,
                     32'h8000_0000, 1'b1, 12);
        vecs[5] = mk(1, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, -1, 0, 2, 1'b0, 32'hDEAD_BEEF,
                     1'b0, 3);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Abort during the second word's settle window; rst also overrides a coincident start.
        start = 1'b1;
        num_words = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data = 32'd20;
        tick();
        in_valid = 1'b0;
        check("mid_settle_en", {31'h0, add_en}, 32'h1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_valid", {31'h0, out_valid}, 32'h0);
        check("abort_sum", sum, 32'h0);
        check("abort_add_en", {31'h0, add_en}, 32'h0);
        tick();
        check("abort_stays_idle", {31'h0, busy}, 32'h0);

        run_vec(mk(3, 32'd1, 32'd2, 32'd3, 32'd0, -1, 0, 0, 1'b0, 32'd6, 1'b0, 9), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
